// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the truncated/exact pipelined multiplier.
// The keep predicate decides which partial-product bits survive truncation.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned PROD_W_DEF = 2 * WIDTH_DEF;
  localparam int unsigned SPLIT_DEF  = WIDTH_DEF / 2;

  function automatic int unsigned prod_w(int unsigned width);
    return 2 * width;
  endfunction

  function automatic int unsigned row_split(int unsigned width);
    return width / 2;
  endfunction

  // Partial-product bit x[i]&y[j] is kept in approximate mode when its weight is >= 2^l.
  function automatic logic trunc_mask(int i, int j, int l);
    return (i + j) >= l;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
// master = operand source and result consumer, slave = the multiplier.
interface approx_mult_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic [2*WIDTH-1:0]   err;

  modport master (
    output in_valid, x, y, mode, out_ready,
    input  in_ready, out_valid, z, err
  );

  modport slave (
    input  in_valid, x, y, mode, out_ready,
    output in_ready, out_valid, z, err
  );
endinterface

// File: rtl/approx_pp_rows.sv
// Combinational sum of partial-product rows ROW_LO..ROW_HI-1 of x*y, both with all
// bits and with only the bits kept by truncation level L.
module approx_pp_rows
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned L      = 6,
  parameter int unsigned ROW_LO = 0,
  parameter int unsigned ROW_HI = 4
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] sum_exact,
  output logic [2*WIDTH-1:0] sum_trunc
);

  localparam int unsigned PW    = prod_w(WIDTH);
  localparam int unsigned NROWS = ROW_HI - ROW_LO;

  logic [NROWS-1:0][PW-1:0] rows_e;
  logic [NROWS-1:0][PW-1:0] rows_t;

  for (genvar g = 0; g < NROWS; g++) begin : g_row
    localparam int J = ROW_LO + g;
    logic [WIDTH-1:0] keep;
    logic [WIDTH-1:0] pp;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign keep[i] = trunc_mask(i, J, int'(L));
    end

    assign pp        = x & {WIDTH{y[J]}};
    assign rows_e[g] = {{WIDTH{1'b0}}, pp} << J;
    assign rows_t[g] = {{WIDTH{1'b0}}, pp & keep} << J;
  end

  // Each partial sum is bounded by x*y, so PW bits never overflow.
  always_comb begin
    sum_exact = '0;
    sum_trunc = '0;
    for (int g = 0; g < NROWS; g++) begin
      sum_exact = sum_exact + rows_e[g];
      sum_trunc = sum_trunc + rows_t[g];
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined unsigned multiplier with per-operation exact/truncated result,
// per-result error, global-stall backpressure and transfer/max-error statistics.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned L     = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_mult_pipe_if.slave    bus,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     op_cnt,
  output logic [2*WIDTH-1:0]   max_err
);

  localparam int unsigned PW    = prod_w(WIDTH);
  localparam int unsigned SPLIT = row_split(WIDTH);

  logic adv;
  logic xfer;

  // S1
  logic             v1_q;
  logic [WIDTH-1:0] x1_q;
  logic [WIDTH-1:0] y1_q;
  mode_e            mode1_q;

  // S2
  logic             v2_q;
  mode_e            mode2_q;
  logic [PW-1:0]    lo_exact_q, lo_trunc_q, hi_exact_q, hi_trunc_q;
  logic [PW-1:0]    lo_exact_d, lo_trunc_d, hi_exact_d, hi_trunc_d;

  // S3
  logic             out_valid_q;
  logic [PW-1:0]    z_q, err_q;
  logic [PW-1:0]    z_d, err_d;

  logic [CNT_W-1:0] op_cnt_q;
  logic [PW-1:0]    max_err_q;

  // Whole pipe moves as one; a held result freezes every stage behind it.
  assign adv          = !out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign xfer         = out_valid_q & bus.out_ready;

  approx_pp_rows #(
    .WIDTH  (WIDTH),
    .L      (L),
    .ROW_LO (0),
    .ROW_HI (SPLIT)
  ) u_rows_lo (
    .x         (x1_q),
    .y         (y1_q),
    .sum_exact (lo_exact_d),
    .sum_trunc (lo_trunc_d)
  );

  approx_pp_rows #(
    .WIDTH  (WIDTH),
    .L      (L),
    .ROW_LO (SPLIT),
    .ROW_HI (WIDTH)
  ) u_rows_hi (
    .x         (x1_q),
    .y         (y1_q),
    .sum_exact (hi_exact_d),
    .sum_trunc (hi_trunc_d)
  );

  always_comb begin
    logic [PW-1:0] exact_sum;
    logic [PW-1:0] trunc_sum;
    exact_sum = lo_exact_q + hi_exact_q;
    trunc_sum = lo_trunc_q + hi_trunc_q;
    z_d       = (mode2_q == MODE_APPROX) ? trunc_sum : exact_sum;
    err_d     = exact_sum - z_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      mode1_q     <= MODE_EXACT;
      v2_q        <= 1'b0;
      mode2_q     <= MODE_EXACT;
      lo_exact_q  <= '0;
      lo_trunc_q  <= '0;
      hi_exact_q  <= '0;
      hi_trunc_q  <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      err_q       <= '0;
    end else if (adv) begin
      v1_q        <= bus.in_valid;
      x1_q        <= bus.x;
      y1_q        <= bus.y;
      mode1_q     <= mode_e'(bus.mode);
      v2_q        <= v1_q;
      mode2_q     <= mode1_q;
      lo_exact_q  <= lo_exact_d;
      lo_trunc_q  <= lo_trunc_d;
      hi_exact_q  <= hi_exact_d;
      hi_trunc_q  <= hi_trunc_d;
      out_valid_q <= v2_q;
      z_q         <= z_d;
      err_q       <= err_d;
    end
  end

  // Clear wins over a coincident transfer, which is then not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q  <= '0;
      max_err_q <= '0;
    end else if (stat_clr) begin
      op_cnt_q  <= '0;
      max_err_q <= '0;
    end else if (xfer) begin
      if (op_cnt_q != '1) begin
        op_cnt_q <= op_cnt_q + 1'b1;
      end
      if (err_q > max_err_q) begin
        max_err_q <= err_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.err       = err_q;
  assign op_cnt        = op_cnt_q;
  assign max_err       = max_err_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe (WIDTH=8, L=6) with hand-computed
// products, stall/ordering, statistics-clear and mid-flight reset scenarios.
module tb_approx_mult_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] op_cnt;
  logic [PW-1:0]    max_err;

  int n_assert = 0;
  int n_fail   = 0;

  approx_mult_pipe_if #(.WIDTH(WIDTH)) bif ();

  approx_mult_pipe #(
    .WIDTH (WIDTH),
    .L     (6),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .stat_clr (stat_clr),
    .op_cnt   (op_cnt),
    .max_err  (max_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated operation with out_ready held high; checks latency, z and err.
  task automatic send_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic [15:0] ez, input logic [15:0] ee);
    int lat;
    bif.in_valid  = 1'b1;
    bif.x         = a;
    bif.y         = b;
    bif.mode      = m;
    bif.out_ready = 1'b1;
    step();
    bif.in_valid = 1'b0;
    lat = 1;
    while (!bif.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_z"}, bif.z, ez);
    chk({tag, "_err"}, bif.err, ee);
    step();
  endtask

  logic [7:0]  sx [4] = '{8'd255, 8'd255, 8'd3, 8'd100};
  logic [7:0]  sy [4] = '{8'd255, 8'd255, 8'd3, 8'd50};
  logic        sm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] sz [4] = '{16'd64704, 16'd65025, 16'd0, 16'd5000};
  logic [15:0] se [4] = '{16'd321, 16'd0, 16'd9, 16'd0};

  initial begin
    int sent;
    int got;
    int seen;
    bit saw_block;
    int lat;

    bif.in_valid  = 1'b0;
    bif.x         = '0;
    bif.y         = '0;
    bif.mode      = 1'b0;
    bif.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_z", bif.z, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_max_err", max_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // 1: 255*255 approx, 321 worth of dropped low-column bits
    send_op("t1", 8'd255, 8'd255, 1'b1, 16'd64704, 16'd321);
    chk("t1_op_cnt", op_cnt, 1);
    chk("t1_max_err", max_err, 321);
    chk("t1_idle", bif.out_valid, 0);

    // 2, 3: all-dropped, exact, all-kept and zero operands
    send_op("t2a", 8'd3, 8'd3, 1'b1, 16'd0, 16'd9);
    send_op("t2e", 8'd3, 8'd3, 1'b0, 16'd9, 16'd0);
    send_op("t3a", 8'd128, 8'd128, 1'b1, 16'd16384, 16'd0);
    send_op("t3z1", 8'd0, 8'd200, 1'b1, 16'd0, 16'd0);
    send_op("t3z0", 8'd0, 8'd200, 1'b0, 16'd0, 16'd0);
    chk("t3_op_cnt", op_cnt, 6);
    chk("t3_max_err", max_err, 321);

    // 4: back-to-back stream, 5-cycle consumer stall mid-stream
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t4_clr_cnt", op_cnt, 0);
    sent = 0;
    got = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      bif.out_ready = !(c >= 3 && c < 8);
      #1;
      if (bif.out_valid) begin
        chk($sformatf("t4_z%0d_c%0d", got, c), bif.z, sz[got]);
        chk($sformatf("t4_err%0d_c%0d", got, c), bif.err, se[got]);
        if (bif.out_ready) got++;
      end
      if (sent < 4) begin
        bif.in_valid = 1'b1;
        bif.x        = sx[sent];
        bif.y        = sy[sent];
        bif.mode     = sm[sent];
        if (!bif.in_ready) saw_block = 1'b1;
        else sent++;
      end else begin
        bif.in_valid = 1'b0;
      end
      step();
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    chk("t4_got", got, 4);
    chk("t4_in_ready_dropped", saw_block, 1);
    chk("t4_op_cnt", op_cnt, 4);
    chk("t4_max_err", max_err, 321);

    // 5: clear coincident with a transfer (10*10 approx -> 64, err 36)
    bif.in_valid = 1'b1;
    bif.x        = 8'd10;
    bif.y        = 8'd10;
    bif.mode     = 1'b1;
    step();
    bif.in_valid = 1'b0;
    lat = 1;
    while (!bif.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("t5_z", bif.z, 64);
    chk("t5_err", bif.err, 36);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t5_clr_cnt", op_cnt, 0);
    chk("t5_clr_max", max_err, 0);
    chk("t5_drained", bif.out_valid, 0);
    send_op("t5b", 8'd255, 8'd255, 1'b1, 16'd64704, 16'd321);
    chk("t5b_op_cnt", op_cnt, 1);
    chk("t5b_max_err", max_err, 321);

    // 6: reset with three operations in flight
    bif.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bif.in_valid = 1'b1;
      bif.x        = 8'd20 + 8'(k);
      bif.y        = 8'd7;
      bif.mode     = 1'b0;
      step();
    end
    bif.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", bif.out_valid, 0);
    chk("t6_op_cnt", op_cnt, 0);
    chk("t6_max_err", max_err, 0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bif.out_valid) seen++;
    end
    chk("t6_no_stale", seen, 0);
    send_op("t6f", 8'd200, 8'd100, 1'b0, 16'd20000, 16'd0);
    chk("t6f_op_cnt", op_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
Parametrised, pipelined unsigned WIDTH x WIDTH multiplier with a per-operation choice between an exact result and a truncated approximate result.
- Approximate mode discards every partial-product bit whose column weight is below 2^L.
- Both results are produced in parallel, so every output carries its own error value.
- Valid/ready handshakes on input and output; a whole-pipe stall applies backpressure.
- A statistics unit (transfer count, maximum error) supports on-chip accuracy characterisation.
- Sits between operand sources and accumulators in the datapath.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..16.
L, 6, truncation level; partial products x[i]&y[j] with i+j < L are dropped in approx mode; legal range 0..2*WIDTH-2; L=0 makes approx equal to exact.
CNT_W, 32, width of the transfer counter.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept operands this cycle.
x  in  WIDTH  multiplicand, unsigned.
y  in  WIDTH  multiplier, unsigned.
mode  in  1  0 = exact, 1 = approximate; sampled with the operands.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
z  out  2*WIDTH  product (exact or approximate per captured mode).
err  out  2*WIDTH  exact product minus z; always 0 when the captured mode is 0.
stat_clr  in  1  synchronous clear of the statistics.
op_cnt  out  CNT_W  number of completed output transfers; saturates at all-ones.
max_err  out  2*WIDTH  largest err among transferred results since reset or clear.

Behaviour:
Reset:
- Asynchronous assert of rst clears all stage valid bits, out_valid, z, err, op_cnt and max_err to 0.
- in_ready is 1 out of reset.

Pipeline:
- Three register stages.
  - S1 captures x, y and mode.
  - S2 holds two partial sums: rows 0..WIDTH/2-1 and rows WIDTH/2..WIDTH-1. Each partial sum is computed both with all bits and with only the bits where i+j >= L.
  - S3 holds z, err and out_valid.
- Global advance enable: adv = !out_valid | out_ready. All stages shift together when adv=1; every stage holds when adv=0.
- in_ready = adv, which is combinational from out_valid and out_ready.
- Latency: a transfer at cycle t (in_valid & in_ready) produces out_valid at t+3 if out_ready stays high. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Bubbles: a stage with its valid bit 0 still shifts; bubbles are squeezed out only by normal advancing, with no compaction.
- Ordering: results leave in input order. mode travels with its operands, so mode changes between consecutive operations are legal.

Arithmetic:
- exact = x*y, computed at full 2*WIDTH width with no overflow possible.
- approx = sum over i+j >= L of (x[i]&y[j]) << (i+j).
- approx <= exact always, so err = exact - approx is non-negative and fits in 2*WIDTH bits.

Statistics:
- Updated only on an output transfer (out_valid & out_ready).
- On each transfer, op_cnt increments (holding at all-ones) and max_err = max(max_err, err).
- stat_clr=1 clears both registers on the next edge. It takes priority over a coincident transfer, so that transfer is not counted.

Boundary cases:
- Stall while full: operands, mode and results are held unchanged; no data is lost or duplicated.
- Reset mid-operation: in-flight operations are discarded and no output is produced for them.
- out_ready may be high while out_valid is low; this has no effect.

Decomposition:
- Shared package (approx_mult_pkg):
  - function trunc_mask(i, j, L), the keep predicate for a partial-product bit.
  - localparams for the product width (2*WIDTH) and the row split point (WIDTH/2).
  - a mode enum: MODE_EXACT=0, MODE_APPROX=1.
- One sub-module, approx_pp_rows: purely combinational. Given operands, a row range and L, it outputs the exact and truncated sums of those rows. It is instantiated twice in the S1->S2 logic.
- Handshake, stage registers and the statistics unit stay in the top module.

Test Plan:
1. WIDTH=8, L=6, mode=1, x=255, y=255, out_ready=1 -> 3 cycles later z=64704, err=321; op_cnt=1, max_err=321.
2. mode=1, x=3, y=3 -> z=0, err=9; mode=0, same operands -> z=9, err=0.
3. mode=1, x=128, y=128 -> z=16384, err=0. Also x=0, y=200 in both modes -> z=0, err=0.
4. Back-to-back stream of 4 operations with alternating modes, out_ready held low for 5 cycles mid-stream:
   - in_ready drops once the pipe is full;
   - results emerge in order with values unchanged;
   - op_cnt=4 at the end.
5. Assert stat_clr in the same cycle as a transfer -> op_cnt=0, max_err=0 on the next cycle. The next transfer (x=255, y=255, mode=1) gives op_cnt=1, max_err=321.
6. Assert rst while 3 operations are in flight -> out_valid, op_cnt and max_err are 0 immediately. No stale result appears after rst deasserts; a fresh operation returns after 3 cycles.
